mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register: it reads the registered EX/MEM memory-control, address and store-data outputs.
- Drives a multi-cycle data memory through a request/valid handshake.
- Returns load data to the MEM/WB path.
- Generates `stall`, which the pipeline inverts into the WriteEnable of the upstream pipeline registers (PC, IF/ID, ID/EX, EX/MEM) while an access is outstanding.

Parameters:
- TIMEOUT, 16: max cycles in BUSY waiting for mem_valid before an error abort.
- CW, $clog2(TIMEOUT+1): width of the wait counter. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- EXMEMMemRead  input  1  load request from the EX/MEM register.
- EXMEMMemWrite  input  1  store request from the EX/MEM register.
- EXMEMalu_out  input  16  effective address.
- EXMEMwrite_data  input  16  store data.
- mem_req  output  1  one-cycle request pulse to data memory.
- mem_we  output  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  output  16  latched address; held stable from request through completion.
- mem_wdata  output  16  latched store data; held stable like mem_addr.
- mem_valid  input  1  memory completion pulse.
- mem_rdata  input  16  read data; valid when mem_valid=1.
- stall  output  1  combinational; 1 = hold upstream pipeline registers.
- mem_out_data  output  16  registered load result.
- mem_out_valid  output  1  one-cycle pulse in DONE.
- mem_err  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, mem_out_data, mem_out_valid, mem_err and the counter all go to 0. Reset mid-access abandons the access; a later mem_valid is ignored.
- op = EXMEMMemRead | EXMEMMemWrite.
- stall = (state==IDLE && op) || state==BUSY. It is 0 in DONE and when IDLE with no op.
- IDLE:
  - If op: at the clock edge latch mem_addr=EXMEMalu_out, mem_wdata=EXMEMwrite_data, mem_we=EXMEMMemWrite; set mem_req=1; clear counter; go to BUSY.
  - If both MemRead and MemWrite are 1: treat as a write and set mem_err.
- BUSY:
  - mem_req is 1 only in the first BUSY cycle, then 0.
  - mem_valid sampled in that request cycle is ignored; it is accepted from the following cycle on.
  - Counter increments every BUSY cycle.
  - On accepted mem_valid: if the access is a read, mem_out_data <= mem_rdata. Go to DONE.
  - If counter==TIMEOUT with no mem_valid: set mem_err, set mem_out_data <= 16'hFFFF (read only), go to DONE.
  - If mem_valid and the timeout occur in the same cycle, mem_valid wins and mem_err is not set.
- DONE: exactly one cycle. mem_out_valid=1, stall=0 (the EX/MEM register advances at this edge). Next state is unconditionally IDLE, so the request just served is never re-issued.
- Back-to-back: IDLE samples the new EX/MEM contents the cycle after DONE. Consecutive memory ops therefore each cost (L+2) stall cycles plus one DONE cycle, where L = mem_valid delay after the request cycle.
- Stores leave mem_out_data unchanged.
- mem_valid in IDLE or DONE is ignored.
- mem_addr, mem_wdata and mem_we hold their last values in IDLE.
- mem_err is sticky until reset.
- No arithmetic on the address; 16-bit values pass unmodified.

Test Plan:
- Reset: assert rst=0 mid-BUSY -> state IDLE immediately; all outputs 0; a later mem_valid is ignored.
- Load, L=4: MemRead=1, addr=16'h0040, mem_rdata=16'hBEEF on mem_valid 4 cycles after mem_req -> mem_req pulses once with mem_we=0 and mem_addr=16'h0040; stall high 6 cycles; mem_out_data=16'hBEEF with a 1-cycle mem_out_valid.
- Store, L=1: MemWrite=1, addr=16'h0010, data=16'h1234 -> mem_we=1, mem_wdata=16'h1234, stall 3 cycles; mem_out_data keeps its prior value.
- Back-to-back load then store, L=2: two separate mem_req pulses, with one non-stall DONE cycle between the accesses; no duplicate request.
- Timeout, TIMEOUT=16, mem_valid never asserted on a read -> after 16 BUSY cycles mem_err=1, mem_out_data=16'hFFFF, DONE, then IDLE; mem_err stays 1 until reset.
- Illegal MemRead=MemWrite=1 -> write issued (mem_we=1) and mem_err=1; mem_valid arriving in the request cycle is ignored and a second mem_valid one cycle later completes the access.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   MEM-stage access controller. Takes the registered EX/MEM memory controls,
//   issues one request per memory op to a multi-cycle data memory, waits for
//   its completion pulse (bounded by TIMEOUT), returns load data toward MEM/WB,
//   and holds the upstream pipeline through stall while an access is pending.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no access pending; an op on the EX/MEM outputs starts one
//   BUSY  | request issued, waiting for mem_valid or the wait limit
//   DONE  | one-cycle completion; pipeline advances, mem_out_valid high
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   EXMEMMemRead       load request from EX/MEM
//   EXMEMMemWrite      store request from EX/MEM
//   EXMEMalu_out       effective address
//   EXMEMwrite_data    store data
//   mem_req            one-cycle request pulse to data memory
//   mem_we             1 = write, 0 = read (valid with mem_req)
//   mem_addr           latched address, stable until the next access
//   mem_wdata          latched store data, stable until the next access
//   mem_valid          completion pulse from data memory
//   mem_rdata          read data, valid with mem_valid
//   stall              combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   mem_out_data       registered load result (0xFFFF on read timeout)
//   mem_out_valid      one-cycle pulse in DONE
//   mem_err            sticky error (timeout or read+write together)

module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXMEMMemRead,
  input  logic        EXMEMMemWrite,
  input  logic [15:0] EXMEMalu_out,
  input  logic [15:0] EXMEMwrite_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_valid,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic [15:0] mem_out_data,
  output logic        mem_out_valid,
  output logic        mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          op;
  logic          accept;
  logic          expired;

  assign op = EXMEMMemRead | EXMEMMemWrite;

  // mem_req is high exactly in the first BUSY cycle, so it doubles as the
  // marker for the request cycle in which a completion pulse is not trusted.
  assign accept = mem_valid & ~mem_req;

  // wait_cnt holds the number of BUSY cycles already finished; the limit is
  // reached in the TIMEOUT-th BUSY cycle.
  assign expired = (wait_cnt == CW'(TIMEOUT - 1));

  assign stall = ((state == IDLE) & op) | (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 16'h0000;
      mem_wdata     <= 16'h0000;
      mem_out_data  <= 16'h0000;
      mem_out_valid <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_out_valid <= 1'b0;
          if (op) begin
            mem_addr  <= EXMEMalu_out;
            mem_wdata <= EXMEMwrite_data;
            // Read+write together is resolved as a write and flagged.
            mem_we    <= EXMEMMemWrite;
            mem_req   <= 1'b1;
            wait_cnt  <= '0;
            if (EXMEMMemRead && EXMEMMemWrite) begin
              mem_err <= 1'b1;
            end
            state <= BUSY;
          end
        end

        BUSY: begin
          mem_req  <= 1'b0;
          wait_cnt <= wait_cnt + CW'(1);
          if (accept) begin
            if (!mem_we) begin
              mem_out_data <= mem_rdata;
            end
            mem_out_valid <= 1'b1;
            state         <= DONE;
          end else if (expired) begin
            mem_err <= 1'b1;
            if (!mem_we) begin
              mem_out_data <= 16'hFFFF;
            end
            mem_out_valid <= 1'b1;
            state         <= DONE;
          end
        end

        DONE: begin
          // EX/MEM advances on this edge, so return to IDLE without looking
          // at the (stale) op inputs; the served request is never re-issued.
          mem_out_valid <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          mem_req       <= 1'b0;
          mem_out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [15:0] alu_out;
  logic [15:0] wdata_in;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_valid;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] out_data;
  logic        out_valid;
  logic        mem_err;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .EXMEMMemRead   (rd),
    .EXMEMMemWrite  (wr),
    .EXMEMalu_out   (alu_out),
    .EXMEMwrite_data(wdata_in),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_valid      (mem_valid),
    .mem_rdata      (mem_rdata),
    .stall          (stall),
    .mem_out_data   (out_data),
    .mem_out_valid  (out_valid),
    .mem_err        (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int abs_cyc = 0;
  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  int vecs = 0;
  int fails = 0;

  // Transaction-level reference state.
  logic [15:0] m_out;
  logic        m_err;

  // Observations of the last access.
  int          o_stall;
  int          o_reqs;
  bit          o_done;
  logic        o_we;
  logic [15:0] o_addr;
  logic [15:0] o_wdata;
  logic [15:0] o_data;
  logic        o_err;
  logic        o_stall_done;
  int          o_req_abs;
  int          o_done_abs;

  task automatic apply_reset();
    rst = 1'b0;
    rd = 1'b0; wr = 1'b0; alu_out = 16'h0; wdata_in = 16'h0;
    mem_valid = 1'b0; mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m_out = 16'h0000;
    m_err = 1'b0;
  endtask

  // Presents one op on the EX/MEM outputs (called at posedge+1) and plays a
  // memory that answers lat cycles after the request cycle. early adds a
  // spurious completion during the request cycle.
  task automatic do_access(input logic r, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input int lat,
                           input logic [15:0] rdata, input bit early);
    int  n;
    int  req_n;
    bit  req_seen;
    rd = r; wr = w; alu_out = a; wdata_in = d;
    mem_valid = 1'b0;
    n = 0; req_n = 0; req_seen = 0;
    o_stall = 0; o_reqs = 0; o_done = 0; o_we = 1'b0; o_addr = 16'h0;
    o_wdata = 16'h0; o_data = 16'h0; o_err = 1'b0; o_stall_done = 1'b1;
    o_req_abs = 0; o_done_abs = 0;
    while (!o_done && n < 60) begin
      @(negedge clk);
      if (stall) o_stall++;
      if (mem_req) begin
        o_reqs++;
        if (!req_seen) begin
          req_seen = 1; req_n = n;
          o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
          o_req_abs = abs_cyc;
        end
      end
      if (out_valid) begin
        o_done = 1; o_data = out_data; o_err = mem_err;
        o_stall_done = stall; o_done_abs = abs_cyc;
      end
      @(posedge clk); #1;
      n++;
      mem_valid = 1'b0;
      mem_rdata = 16'($urandom);
      if (o_done) begin
        rd = 1'b0; wr = 1'b0;
      end else if (early && n == 1) begin
        mem_valid = 1'b1;
      end else if (req_seen && n == req_n + lat) begin
        mem_valid = 1'b1;
        mem_rdata = rdata;
      end
    end
    rd = 1'b0; wr = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    apply_reset();
    @(negedge clk);
    vecs++; if ({mem_req, mem_we, out_valid, mem_err, stall} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, out_valid, mem_err, stall});
    end
    vecs++; if ({mem_addr, mem_wdata, out_data} !== 48'h0) begin
      fails++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, out_data});
    end
    // Start a read, then reset in the middle of BUSY.
    @(posedge clk); #1;
    rd = 1'b1; alu_out = 16'h7777; wdata_in = 16'h3333;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd = 1'b0;
    #1 rst = 1'b0;
    #1;
    vecs++; if ({mem_req, mem_we, out_valid, mem_err, stall} !== 5'b0) begin
      fails++; $display("FAIL reset_mid_ctrl: got %b want 00000", {mem_req, mem_we, out_valid, mem_err, stall});
    end
    vecs++; if ({mem_addr, mem_wdata, out_data} !== 48'h0) begin
      fails++; $display("FAIL reset_mid_data: got %h want 0", {mem_addr, mem_wdata, out_data});
    end
    @(posedge clk); #1 rst = 1'b1;
    mem_valid = 1'b1; mem_rdata = 16'hDEAD;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || mem_req || stall) pulses++;
      @(posedge clk); #1 mem_valid = 1'b0;
    end
    vecs++; if (pulses !== 0 || out_data !== 16'h0) begin
      fails++; $display("FAIL reset_late_valid: activity=%0d data=%h want 0/0000", pulses, out_data);
    end
    m_out = 16'h0000; m_err = 1'b0;
  endtask

  task automatic test_load();
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 4, 16'hBEEF, 0);
    m_out = 16'hBEEF;
    vecs++; if (!o_done) begin fails++; $display("FAIL load_done: no completion"); end
    vecs++; if (o_reqs !== 1 || o_we !== 1'b0 || o_addr !== 16'h0040) begin
      fails++; $display("FAIL load_req: reqs=%0d we=%b addr=%h want 1/0/0040", o_reqs, o_we, o_addr);
    end
    vecs++; if (o_stall !== 6) begin fails++; $display("FAIL load_stall: got %0d want 6", o_stall); end
    vecs++; if (o_data !== m_out || o_err !== 1'b0) begin
      fails++; $display("FAIL load_data: data=%h err=%b want %h/0", o_data, o_err, m_out);
    end
    @(negedge clk);
    vecs++; if (out_valid !== 1'b0) begin fails++; $display("FAIL load_valid_pulse: got %b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 1, 16'h9999, 0);
    vecs++; if (o_we !== 1'b1 || o_wdata !== 16'h1234 || o_addr !== 16'h0010) begin
      fails++; $display("FAIL store_req: we=%b wdata=%h addr=%h want 1/1234/0010", o_we, o_wdata, o_addr);
    end
    vecs++; if (o_stall !== 3) begin fails++; $display("FAIL store_stall: got %0d want 3", o_stall); end
    vecs++; if (!o_done || o_data !== m_out) begin
      fails++; $display("FAIL store_keep: done=%0d data=%h want 1/%h", o_done, o_data, m_out);
    end
  endtask

  task automatic test_back_to_back();
    int s1, r1, d1_abs;
    logic sd1;
    do_access(1'b1, 1'b0, 16'h0080, 16'h0000, 2, 16'h5A5A, 0);
    m_out = 16'h5A5A;
    s1 = o_stall; r1 = o_reqs; d1_abs = o_done_abs; sd1 = o_stall_done;
    do_access(1'b0, 1'b1, 16'h0090, 16'h0F0F, 2, 16'h1111, 0);
    vecs++; if (s1 !== 4 || o_stall !== 4) begin
      fails++; $display("FAIL b2b_stall: got %0d/%0d want 4/4", s1, o_stall);
    end
    vecs++; if (r1 !== 1 || o_reqs !== 1) begin
      fails++; $display("FAIL b2b_reqs: got %0d/%0d want 1/1", r1, o_reqs);
    end
    vecs++; if (sd1 !== 1'b0 || o_req_abs - d1_abs !== 2) begin
      fails++; $display("FAIL b2b_gap: done_stall=%b gap=%0d want 0/2", sd1, o_req_abs - d1_abs);
    end
    vecs++; if (o_data !== m_out || o_we !== 1'b1) begin
      fails++; $display("FAIL b2b_data: data=%h we=%b want %h/1", o_data, o_we, m_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic        r;
      logic [15:0] a, d, rdat;
      int          lat, exp_stall;
      bit          completes;
      r    = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      d    = 16'($urandom);
      rdat = 16'($urandom);
      lat  = $urandom_range(1, TIMEOUT + 2);
      do_access(r, ~r, a, d, lat, rdat, 0);
      completes = (lat <= TIMEOUT - 1);
      exp_stall = completes ? lat + 2 : TIMEOUT + 1;
      if (r) m_out = completes ? rdat : 16'hFFFF;
      if (!completes) m_err = 1'b1;
      vecs++; if (!o_done || o_reqs !== 1) begin
        fails++; $display("FAIL rnd%0d_done: done=%0d reqs=%0d want 1/1", i, o_done, o_reqs);
      end
      vecs++; if (o_stall !== exp_stall) begin
        fails++; $display("FAIL rnd%0d_stall: lat=%0d got %0d want %0d", i, lat, o_stall, exp_stall);
      end
      vecs++; if (o_we !== ~r || o_addr !== a || o_wdata !== d) begin
        fails++; $display("FAIL rnd%0d_req: we=%b addr=%h wdata=%h want %b/%h/%h", i, o_we, o_addr, o_wdata, ~r, a, d);
      end
      vecs++; if (o_data !== m_out || o_err !== m_err) begin
        fails++; $display("FAIL rnd%0d_out: data=%h err=%b want %h/%b", i, o_data, o_err, m_out, m_err);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    do_access(1'b1, 1'b0, 16'h0100, 16'h0000, 1000, 16'h0000, 0);
    vecs++; if (!o_done || o_stall !== TIMEOUT + 1) begin
      fails++; $display("FAIL timeout_len: done=%0d stall=%0d want 1/%0d", o_done, o_stall, TIMEOUT + 1);
    end
    vecs++; if (o_data !== 16'hFFFF || o_err !== 1'b1) begin
      fails++; $display("FAIL timeout_out: data=%h err=%b want ffff/1", o_data, o_err);
    end
    do_access(1'b0, 1'b1, 16'h0104, 16'h4321, 3, 16'h0000, 0);
    vecs++; if (o_err !== 1'b1 || o_data !== 16'hFFFF || o_stall !== 5) begin
      fails++; $display("FAIL timeout_sticky: err=%b data=%h stall=%0d want 1/ffff/5", o_err, o_data, o_stall);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    do_access(1'b1, 1'b1, 16'h0200, 16'hA5A5, 1, 16'hCCCC, 1);
    vecs++; if (o_we !== 1'b1 || o_wdata !== 16'hA5A5 || o_reqs !== 1) begin
      fails++; $display("FAIL illegal_req: we=%b wdata=%h reqs=%0d want 1/a5a5/1", o_we, o_wdata, o_reqs);
    end
    vecs++; if (o_stall !== 3 || o_err !== 1'b1) begin
      fails++; $display("FAIL illegal_flow: stall=%0d err=%b want 3/1", o_stall, o_err);
    end
    vecs++; if (o_data !== 16'h0000) begin
      fails++; $display("FAIL illegal_data: got %h want 0000", o_data);
    end
  endtask

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0; alu_out = 16'h0; wdata_in = 16'h0;
    mem_valid = 1'b0; mem_rdata = 16'h0;
    m_out = 16'h0; m_err = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_timeout();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
